pipeline_serializer: RTL and testbench
======================================

// Module: pipeline_serializer
//
// PURPOSE
// Reader-side companion to the ready/valid half-buffer: accepts one wide word
// and emits it as a sequence of narrow pieces.
// - Input and output handshakes are decoupled; there is no combinational path
//   from either handshake to the other.
// - Sits between a wide-datapath producer and a narrow link or consumer.
// - Trades throughput for freedom from combinational ready/valid chains.
//
// PARAMETERS
// WORD_WIDTH   32  width of input word; must be an integer multiple of PIECE_WIDTH
// PIECE_WIDTH  8   width of each output piece
// MSB_FIRST    0   0: emit bits [PIECE_WIDTH-1:0] first; 1: emit top piece first
// RESET_VALUE  0   value loaded into the word register on reset (WORD_WIDTH bits)
// (derived) PIECE_COUNT = WORD_WIDTH/PIECE_WIDTH, >=1; counter width max(1,clog2(PIECE_COUNT))
//
// PORTS
// clock           in   1            single clock; all state changes on rising edge
// clear_n         in   1            reset, asynchronous, active-low
// data_in_valid   in   1            input word offered
// data_in_ready   out  1            serializer can accept a word
// data_in         in   WORD_WIDTH   input word
// data_out_valid  out  1            a piece is presented
// data_out_ready  in   1            consumer takes the piece
// data_out        out  PIECE_WIDTH  current piece
// data_out_last   out  1            current piece is the final piece of its word
//
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - While clear_n is low:
//   - state = EMPTY, word register = RESET_VALUE, count = 0.
//   - data_out_valid = 0, data_out_last = 0, data_in_ready = 0 (gated low).
//   - data_in_ready rises combinationally with clear_n release.
//   - Reset mid-word discards the remaining pieces; no partial word resumes.
// - States (one bit):
//   - EMPTY: data_in_ready = 1, data_out_valid = 0.
//   - SHIFTING: data_in_ready = 0, data_out_valid = 1.
//   - Both outputs are decoded from the state register only.
// - EMPTY -> SHIFTING when data_in_valid = 1:
//   - load word register with data_in.
//   - count = PIECE_COUNT-1.
// - SHIFTING, on output handshake (data_out_valid & data_out_ready):
//   - If count == 0, go to EMPTY.
//   - Otherwise shift the word register by PIECE_WIDTH toward the emit end,
//     zero-fill the vacated piece, and decrement count.
// - data_out:
//   - Equals the emit-end piece of the word register (low piece if
//     MSB_FIRST = 0, high piece if 1).
//   - Comes straight from a register; no logic on the output path.
// - data_out_last = SHIFTING & (count == 0).
// - With valid=1 and ready=0, data_out and data_out_last hold stable.
//   data_out_valid never drops before its handshake.
// - Latency: word accepted on edge N -> first piece valid after edge N.
// - Throughput: PIECE_COUNT+1 cycles per word with data_out_ready held high.
//   There is one mandatory EMPTY bubble, because accepting on the last output
//   handshake would create an out->in combinational path.
// - data_in_valid during SHIFTING is ignored (ready = 0); the upstream
//   producer holds its word.
// - PIECE_COUNT = 1: behaves as a half-buffer; data_out_last = 1 whenever
//   valid. Count logic degenerates to constant 0.
// - Elaboration must fail (error) if WORD_WIDTH % PIECE_WIDTH != 0 or
//   PIECE_WIDTH < 1.
//
// TESTING
// 1. Reset: hold clear_n=0 with data_in_valid=1, data_in=32'hDEADBEEF
//    -> ready=0 and valid=0 throughout; nothing accepted after release until
//    the next valid cycle.
// 2. LSB-first, out_ready=1: send 32'h44332211 -> pieces 11,22,33,44 on
//    consecutive cycles, last=1 only with 44. Next word accepted 1 cycle after
//    the 44 handshake (5-cycle period).
// 3. Backpressure: MSB_FIRST=1, send 32'hA1B2C3D4, out_ready low 3 cycles per
//    piece -> A1,B2,C3,D4 each held stable while stalled; no piece dropped or
//    duplicated.
// 4. Input during shift: assert data_in_valid with 32'h0BADF00D while
//    SHIFTING -> ready=0, word not loaded. It is accepted only after the last
//    piece and emitted intact afterwards.
// 5. Async reset mid-word: pull clear_n low between pieces 2 and 3 ->
//    valid=0 immediately (no clock needed); after release the next word
//    starts at piece 0 with last correct.
// 6. PIECE_COUNT=1 (WORD_WIDTH=PIECE_WIDTH=8): random valid/ready stream of
//    1000 words -> output sequence equals input sequence, last always 1 when
//    valid.

Source files
------------

// File: rtl/pipeline_serializer.sv
// Purpose: accept one wide word and emit it as PIECE_COUNT narrow pieces, emit-end piece first.
// Latency: first piece valid right after the accepting edge; PIECE_COUNT+1 cycles per word at full rate.
// Backpressure: pieces hold while data_out_ready is low; input ready only when empty, never from output handshake.
module pipeline_serializer #(
    parameter int                      WORD_WIDTH  = 32,
    parameter int                      PIECE_WIDTH = 8,
    parameter bit                      MSB_FIRST   = 1'b0,
    parameter logic [WORD_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic [WORD_WIDTH-1:0]  data_in,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic [PIECE_WIDTH-1:0] data_out,
    output logic                   data_out_last
);

    localparam int PIECE_COUNT = (PIECE_WIDTH > 0) ? (WORD_WIDTH / PIECE_WIDTH) : 1;
    localparam int CW          = (PIECE_COUNT > 1) ? $clog2(PIECE_COUNT) : 1;

    if (PIECE_WIDTH < 1 || (WORD_WIDTH % PIECE_WIDTH) != 0 || PIECE_COUNT < 1) begin : g_bad_params
        $error("pipeline_serializer: WORD_WIDTH must be a positive multiple of PIECE_WIDTH");
    end

    typedef enum logic {
        EMPTY    = 1'b0,
        SHIFTING = 1'b1
    } state_t;

    state_t                  state_q;
    logic [WORD_WIDTH-1:0]   word_q;
    logic [WORD_WIDTH-1:0]   word_shift_d;
    logic [CW-1:0]           count_q;

    // Vacated piece is zero-filled by the logical shift.
    if (MSB_FIRST) begin : g_msb
        assign word_shift_d = word_q << PIECE_WIDTH;
        assign data_out     = word_q[WORD_WIDTH-1 -: PIECE_WIDTH];
    end else begin : g_lsb
        assign word_shift_d = word_q >> PIECE_WIDTH;
        assign data_out     = word_q[PIECE_WIDTH-1:0];
    end

    assign data_in_ready  = clear_n && (state_q == EMPTY);
    assign data_out_valid = (state_q == SHIFTING);
    assign data_out_last  = (state_q == SHIFTING) && (count_q == '0);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= EMPTY;
            word_q  <= RESET_VALUE;
            count_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (data_in_valid) begin
                        word_q  <= data_in;
                        count_q <= CW'(PIECE_COUNT - 1);
                        state_q <= SHIFTING;
                    end
                end
                SHIFTING: begin
                    if (data_out_ready) begin
                        if (count_q == '0) begin
                            state_q <= EMPTY;
                        end else begin
                            word_q  <= word_shift_d;
                            count_q <= count_q - CW'(1);
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_serializer.sv
// Directed bench for pipeline_serializer: LSB-first and MSB-first 32/8 instances plus an 8/8 half-buffer.
module tb_pipeline_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        l_iv = 1'b0, l_ir, l_or = 1'b0, l_ov, l_ol;
    logic [31:0] l_id = '0;
    logic [7:0]  l_od;
    logic        m_iv = 1'b0, m_ir, m_or = 1'b0, m_ov, m_ol;
    logic [31:0] m_id = '0;
    logic [7:0]  m_od;
    logic        h_iv = 1'b0, h_ir, h_or = 1'b0, h_ov, h_ol;
    logic [7:0]  h_id = '0;
    logic [7:0]  h_od;

    pipeline_serializer #(.WORD_WIDTH(32), .PIECE_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clock(clk), .clear_n(rst_n),
        .data_in_valid(l_iv), .data_in_ready(l_ir), .data_in(l_id),
        .data_out_valid(l_ov), .data_out_ready(l_or), .data_out(l_od), .data_out_last(l_ol)
    );

    pipeline_serializer #(.WORD_WIDTH(32), .PIECE_WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clock(clk), .clear_n(rst_n),
        .data_in_valid(m_iv), .data_in_ready(m_ir), .data_in(m_id),
        .data_out_valid(m_ov), .data_out_ready(m_or), .data_out(m_od), .data_out_last(m_ol)
    );

    pipeline_serializer #(.WORD_WIDTH(8), .PIECE_WIDTH(8), .MSB_FIRST(1'b0)) dut_h (
        .clock(clk), .clear_n(rst_n),
        .data_in_valid(h_iv), .data_in_ready(h_ir), .data_in(h_id),
        .data_out_valid(h_ov), .data_out_ready(h_or), .data_out(h_od), .data_out_last(h_ol)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the four LSB-first pieces of w on consecutive cycles with out_ready held high.
    task automatic expect_l(input logic [31:0] w, input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_vld"}, 32'(l_ov), 32'd1);
            chk({tag, "_dat"}, 32'(l_od), 32'(w[8*i +: 8]));
            chk({tag, "_last"}, 32'(l_ol), (i == 3) ? 32'd1 : 32'd0);
            chk({tag, "_inrdy"}, 32'(l_ir), 32'd0);
            tick();
        end
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_b;
    int sent, got, cyc;
    logic [31:0] mw;

    initial begin
        // Reset with a word offered: nothing may be accepted.
        l_iv = 1'b1;
        l_id = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_inrdy", 32'(l_ir), 32'd0);
            chk("rst_vld", 32'(l_ov), 32'd0);
            chk("rst_last", 32'(l_ol), 32'd0);
        end
        l_iv  = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_inrdy", 32'(l_ir), 32'd1);
        tick();
        tick();
        chk("rel_vld", 32'(l_ov), 32'd0);
        chk("rel_inrdy2", 32'(l_ir), 32'd1);

        // LSB-first at full rate, second word waiting: 5-cycle period.
        l_or = 1'b1;
        l_id = 32'h44332211;
        l_iv = 1'b1;
        tick();
        l_id = 32'h88776655;
        expect_l(32'h44332211, "lsb_w1");
        chk("bubble_vld", 32'(l_ov), 32'd0);
        chk("bubble_inrdy", 32'(l_ir), 32'd1);
        tick();
        l_iv = 1'b0;
        expect_l(32'h88776655, "lsb_w2");
        chk("lsb_idle", 32'(l_ov), 32'd0);

        // Input offered during shifting must wait for the bubble.
        l_id = 32'h12345678;
        l_iv = 1'b1;
        tick();
        l_id = 32'h0BADF00D;
        expect_l(32'h12345678, "hold_w1");
        chk("hold_inrdy", 32'(l_ir), 32'd1);
        tick();
        l_iv = 1'b0;
        expect_l(32'h0BADF00D, "hold_w2");

        // Async reset between pieces 2 and 3.
        l_id = 32'hDDCCBBAA;
        l_iv = 1'b1;
        tick();
        l_iv = 1'b0;
        chk("ar_p0", 32'(l_od), 32'hAA);
        tick();
        chk("ar_p1", 32'(l_od), 32'hBB);
        rst_n = 1'b0;
        #1;
        chk("ar_vld", 32'(l_ov), 32'd0);
        chk("ar_last", 32'(l_ol), 32'd0);
        chk("ar_inrdy", 32'(l_ir), 32'd0);
        chk("ar_dat", 32'(l_od), 32'd0);
        tick();
        chk("ar_vld2", 32'(l_ov), 32'd0);
        rst_n = 1'b1;
        l_id  = 32'h04030201;
        l_iv  = 1'b1;
        tick();
        l_iv = 1'b0;
        expect_l(32'h04030201, "ar_w");
        chk("ar_idle", 32'(l_ov), 32'd0);

        // MSB-first with three stall cycles per piece.
        mw   = 32'hA1B2C3D4;
        m_id = mw;
        m_iv = 1'b1;
        tick();
        m_iv = 1'b0;
        for (int p = 0; p < 4; p++) begin
            chk("msb_vld", 32'(m_ov), 32'd1);
            chk("msb_dat", 32'(m_od), 32'(mw[31 - 8*p -: 8]));
            m_or = 1'b0;
            for (int s = 0; s < 3; s++) begin
                tick();
                chk("msb_stall_vld", 32'(m_ov), 32'd1);
                chk("msb_stall_dat", 32'(m_od), 32'(mw[31 - 8*p -: 8]));
                chk("msb_stall_last", 32'(m_ol), (p == 3) ? 32'd1 : 32'd0);
            end
            m_or = 1'b1;
            tick();
        end
        m_or = 1'b0;
        chk("msb_done_vld", 32'(m_ov), 32'd0);
        chk("msb_done_inrdy", 32'(m_ir), 32'd1);

        // Half-buffer: random valid/ready stream checked against a FIFO model.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 1000 && cyc < 20000) begin
            h_iv = (sent < 1000) && ($urandom_range(0, 1) == 1);
            h_id = 8'($urandom_range(0, 255));
            h_or = ($urandom_range(0, 2) != 0);
            if (h_ov && h_or) begin
                if (q.size() == 0) begin
                    chk("h_underflow", 32'(h_od), 32'hFFFF_FFFF);
                end else begin
                    exp_b = q.pop_front();
                    chk("h_dat", 32'(h_od), 32'(exp_b));
                end
                chk("h_last", 32'(h_ol), 32'd1);
                got++;
            end
            if (h_iv && h_ir) begin
                q.push_back(h_id);
                sent++;
            end
            tick();
            cyc++;
        end
        h_iv = 1'b0;
        h_or = 1'b0;
        chk("h_count", 32'(got), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
